// File: rtl/nou_queue_rr_arbiter.sv
// Round-robin arbiter sharing one registered output stage among NUM_REQUESTERS fifo_queue read ports.
// Define NOU_ARB_BURST_EN to let a winner keep priority for up to BURST_LEN consecutive grants.
module nou_queue_rr_arbiter #(
    parameter int NUM_REQUESTERS             = 4,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int REQUESTER_ID_WIDTH_IN_BITS = 2,
    parameter int BURST_LEN                  = 4
) (
    input  logic                                                 clk_in,
    input  logic                                                 reset_in,
    input  logic [NUM_REQUESTERS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_flatted_in,
    input  logic [NUM_REQUESTERS-1:0]                            request_valid_flatted_in,
    output logic [NUM_REQUESTERS-1:0]                            issue_ack_flatted_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                request_out,
    output logic [REQUESTER_ID_WIDTH_IN_BITS-1:0]                request_id_out,
    output logic                                                 request_valid_out,
    input  logic                                                 issue_ack_in
);

    localparam int N   = NUM_REQUESTERS;
    localparam int W   = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int IDW = REQUESTER_ID_WIDTH_IN_BITS;
    localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

    if (IDW != $clog2(N) || N < 2 || BURST_LEN < 1) begin : g_param_check
        $error("nou_queue_rr_arbiter: inconsistent parameters");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_grant_ptr;
    logic [IDW-1:0] search_start;
    logic [IDW-1:0] winner;
    logic [W-1:0]   winner_entry;
    logic           any_valid;
    logic           can_load;
    logic           grant;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] p);
        return (p == LAST_ID) ? '0 : p + IDW'(1);
    endfunction

`ifdef NOU_ARB_BURST_EN
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [CNT_W-1:0] burst_cnt;
    logic             burst_armed;
    logic             keep_priority;

    // burst_armed stops the reset value of last_grant_ptr from claiming a burst before any grant
    assign keep_priority = burst_armed && request_valid_flatted_in[last_grant_ptr]
                           && (int'(burst_cnt) < BURST_LEN - 1);
    assign search_start  = keep_priority ? last_grant_ptr : wrap_inc(last_grant_ptr);

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            burst_cnt   <= '0;
            burst_armed <= 1'b0;
        end else if (grant) begin
            burst_armed <= 1'b1;
            if (winner == last_grant_ptr && keep_priority)
                burst_cnt <= burst_cnt + CNT_W'(1);
            else
                burst_cnt <= '0;
        end
    end
`else
    assign search_start = wrap_inc(last_grant_ptr);
`endif

    always_comb begin
        logic [IDW-1:0] cand;
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDW'((int'(search_start) + k) % N);
            if (!any_valid && request_valid_flatted_in[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    always_comb begin
        winner_entry = '0;
        for (int k = 0; k < N; k++) begin
            if (winner == IDW'(k))
                winner_entry = request_flatted_in[k*W +: W];
        end
    end

    // reset_in gating keeps the upstream acks silent while reset is held
    assign can_load = ~request_valid_out | issue_ack_in;
    assign grant    = reset_in & can_load & any_valid;

    always_comb begin
        issue_ack_flatted_out = '0;
        if (grant)
            issue_ack_flatted_out[winner] = 1'b1;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in)
            last_grant_ptr <= LAST_ID;
        else if (grant)
            last_grant_ptr <= winner;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            request_out    <= '0;
            request_id_out <= '0;
        end else if (grant) begin
            request_out    <= winner_entry;
            request_id_out <= winner;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = BUSY;
            BUSY:    if (issue_ack_in && !grant) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        request_valid_out = (state_q == BUSY);
    end

endmodule

// File: doc/nou_queue_rr_arbiter.md
Name: nou_queue_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream consumer among NUM_REQUESTERS upstream fifo_queue instances inside the NOU.
- Each requester port connects directly to a fifo_queue read side: request_out/request_valid_out in, issue_ack_in out.
- Winner's entry is registered into a single output stage tagged with the requester ID. The output stage uses the same valid/ack handshake, so it can feed another fifo_queue write side or a consumer.

Parameters:
- NUM_REQUESTERS, 4, number of upstream queues (>=2).
- SINGLE_ENTRY_WIDTH_IN_BITS, 64, entry width.
- REQUESTER_ID_WIDTH_IN_BITS, 2, width of the grant index; must equal clog2(NUM_REQUESTERS).
- BURST_LEN, 4, maximum consecutive grants to one requester; used only with NOU_ARB_BURST_EN.

Ports:
- clk_in  input  1  clock, all state on posedge.
- reset_in  input  1  asynchronous active-low reset.
- request_flatted_in  input  NUM_REQUESTERS*SINGLE_ENTRY_WIDTH_IN_BITS  per-requester entries; requester i occupies bits [i*W +: W].
- request_valid_flatted_in  input  NUM_REQUESTERS  per-requester valid.
- issue_ack_flatted_out  output  NUM_REQUESTERS  per-requester consume pulse, combinational, one-hot or zero.
- request_out  output  SINGLE_ENTRY_WIDTH_IN_BITS  registered granted entry.
- request_id_out  output  REQUESTER_ID_WIDTH_IN_BITS  registered index of the granted requester.
- request_valid_out  output  1  registered output valid.
- issue_ack_in  input  1  downstream consumed request_out this cycle.

Behaviour:
- Reset (async, reset_in low):
  - request_out=0, request_id_out=0, request_valid_out=0.
  - last_grant_ptr=NUM_REQUESTERS-1, so requester 0 has first priority.
  - burst_cnt=0, state=IDLE.
- Output stage can_load = ~request_valid_out | issue_ack_in.
- Arbitration is combinational each cycle:
  - Search request_valid_flatted_in starting at last_grant_ptr+1, wrapping from NUM_REQUESTERS-1 to 0.
  - The first valid index is the winner.
  - grant = can_load & (any valid).
- issue_ack_flatted_out[winner] = grant; all other bits 0. Never assert an ack to a requester whose valid is low.
- On a grant, at the next edge:
  - request_out <= winner entry, request_id_out <= winner, request_valid_out <= 1.
  - last_grant_ptr <= winner (non-burst mode).
- If issue_ack_in is high and there is no grant: request_valid_out <= 0 and request_out/request_id_out hold their values.
- If there is no ack and the output is valid: all output registers hold (backpressure). No ack goes upstream.
- Latency: requester valid to request_valid_out is 1 cycle.
- Throughput: with issue_ack_in held high, one entry per cycle, rotating fairly.
- FSM:
  - IDLE: request_valid_out=0. Goes to BUSY on grant.
  - BUSY: request_valid_out=1. Stays in BUSY on a grant, or when there is no ack. Goes to IDLE on ack with no grant.
- Boundaries:
  - A single active requester is granted every cycle it is valid.
  - Pointer wrap from NUM_REQUESTERS-1 to 0 is mandatory.
  - A requester whose valid drops while not granted is simply skipped; there is no latched request.
  - The same requester's next entry (fifo_queue presents it at N+1) is eligible the following cycle.
- reset_in asserted mid-transfer drops any held entry immediately. No ack pulses are generated while in reset.
- issue_ack_in while request_valid_out=0 is ignored.

Optional Feature:
- Macro: NOU_ARB_BURST_EN.
- Defined:
  - burst_cnt counts consecutive grants to last_grant_ptr.
  - While that requester stays valid and burst_cnt < BURST_LEN-1, it keeps priority: the search starts at last_grant_ptr.
  - After BURST_LEN grants, or when its valid drops, the search starts at last_grant_ptr+1 and burst_cnt resets to 0.
  - A grant to a different requester sets burst_cnt=0.
- Undefined:
  - Strict per-grant round-robin.
  - burst_cnt logic is absent and BURST_LEN is ignored.

Test Plan:
- Reset then all 4 valid, issue_ack_in=1 constant, entries 0xA0..0xA3 -> request_id_out sequence 0,1,2,3,0 on consecutive cycles, request_out matching; one ack pulse per cycle.
- Only requester 2 valid, issue_ack_in=1 -> one entry per cycle with request_id_out=2, issue_ack_flatted_out=4'b0100 every cycle.
- Output valid with id 1, issue_ack_in=0 for 5 cycles, requesters 0/3 valid -> request_out/id stable, issue_ack_flatted_out=0; on the ack cycle, requester 3 is granted (after 1).
- Requesters 3 and 0 valid with last_grant_ptr=3 -> grant 0, then 3, checking the wrap-around.
- Drive reset_in low while request_valid_out=1 -> outputs 0 immediately (async); after release, first grant goes to the lowest valid index.
- With NOU_ARB_BURST_EN, BURST_LEN=4, requesters 0 and 1 always valid, ack high -> ids 0,0,0,0,1,1,1,1,0; without the macro -> 0,1,0,1.
